// File: rtl/arthas_pkg.sv
// Shared constants, packed column word and the requantizer for the systolic output path.
// SYSTOLIC_DRAIN_ROUND_EN selects round-half-up before the shift; otherwise the shift truncates.
package arthas_pkg;

    localparam int NBANKS = 2;
    localparam int NCOLS  = 4;
    localparam int QWIDTH = 16;
    localparam int OWIDTH = 33;

    typedef logic [NBANKS-1:0][QWIDTH-1:0] col_word_t;

    localparam logic signed [OWIDTH:0] QMAX = (OWIDTH+1)'((2 ** (QWIDTH-1)) - 1);
    localparam logic signed [OWIDTH:0] QMIN = -QMAX - (OWIDTH+1)'(1);

    // One extra bit of headroom so the rounding increment can never wrap.
    function automatic logic [QWIDTH-1:0] quantize(input logic [OWIDTH-1:0] value,
                                                   input logic [4:0]        shift);
        logic signed [OWIDTH:0] ext;
        logic signed [OWIDTH:0] res;
        ext = $signed({value[OWIDTH-1], value});
`ifdef SYSTOLIC_DRAIN_ROUND_EN
        if (shift != 5'd0) begin
            ext = ext + $signed((OWIDTH+1)'(1) << (shift - 5'd1));
        end
`endif
        res = ext >>> shift;
        if (res > QMAX) begin
            return QMAX[QWIDTH-1:0];
        end else if (res < QMIN) begin
            return QMIN[QWIDTH-1:0];
        end
        return res[QWIDTH-1:0];
    endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Result stream bundle between the systolic array, the drain block and write-back.
// master drives strobes, data, shift, ready and clear; slave is the drain block.
interface systolic_drain_if
    import arthas_pkg::*;
#(
    parameter int nBanks = NBANKS,
    parameter int nCols  = NCOLS,
    parameter int oWidth = OWIDTH,
    parameter int qWidth = QWIDTH
) ();

    logic [4:0]                     shift;
    logic [nCols-1:0]               din_en;
    logic [nBanks*nCols*oWidth-1:0] din;
    logic                           out_valid;
    logic                           out_ready;
    logic [nBanks*qWidth-1:0]       out_data;
    logic [$clog2(nCols)-1:0]       out_col;
    logic                           overflow;
    logic                           ovf_clr;

    modport master (
        output shift, din_en, din, out_ready, ovf_clr,
        input  out_valid, out_data, out_col, overflow
    );

    modport slave (
        input  shift, din_en, din, out_ready, ovf_clr,
        output out_valid, out_data, out_col, overflow
    );

endinterface

// File: rtl/drain_col_fifo.sv
// Per-column result FIFO with occupancy count; DEPTH must be a power of two >= 2.
// Latency: push visible (non-empty) one cycle later; read data is combinational from the head.
// Backpressure: push refused when full unless a pop happens in the same cycle.
module drain_col_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_accept,
    output logic             o_empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNTW-1:0]  r_count;
    logic             w_pop;

    assign o_empty  = (r_count == '0);
    assign w_pop    = i_pop && !o_empty;
    // When full, the slot being written is the one leaving this same cycle.
    assign o_accept = i_push && ((r_count != CNTW'(DEPTH)) || w_pop);
    assign o_dat    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (o_accept) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (o_accept) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({o_accept, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Systolic array output collector: requantize, buffer per column, round-robin drain (SYSTOLIC_DRAIN_ROUND_EN adds rounding).
// Latency: 2 cycles from din_en to out_valid; one beat per cycle while out_ready is high.
// Backpressure: out_ready low freezes the output beat; full FIFOs drop pushes and set sticky overflow.
module systolic_drain
    import arthas_pkg::*;
#(
    parameter int nBanks = NBANKS,
    parameter int nCols  = NCOLS,
    parameter int oWidth = OWIDTH,
    parameter int qWidth = QWIDTH,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    systolic_drain_if.slave bus
);

    localparam int CW = $clog2(nCols);
    localparam int EW = nBanks * qWidth;

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [EW-1:0]    r_data;
    logic [CW-1:0]    r_col;
    logic [CW-1:0]    r_ptr;
    logic             r_ovf;

    logic [EW-1:0]    w_qword    [nCols];
    logic [EW-1:0]    w_fifo_dat [nCols];
    logic [nCols-1:0] w_accept;
    logic [nCols-1:0] w_empty;
    logic [nCols-1:0] w_pop;
    logic [nCols-1:0] w_drop;
    logic             w_load;
    logic             w_take;
    logic             w_gnt_vld;
    logic [CW-1:0]    w_gnt_col;

    always_comb begin
        for (int c = 0; c < nCols; c++) begin
            w_qword[c] = '0;
            for (int b = 0; b < nBanks; b++) begin
                w_qword[c][b*qWidth +: qWidth] =
                    quantize(bus.din[(b*nCols+c)*oWidth +: oWidth], bus.shift);
            end
        end
    end

    for (genvar c = 0; c < nCols; c++) begin : g_col
        drain_col_fifo #(
            .WIDTH (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .i_push   (bus.din_en[c]),
            .i_pop    (w_pop[c]),
            .i_dat    (w_qword[c]),
            .o_dat    (w_fifo_dat[c]),
            .o_accept (w_accept[c]),
            .o_empty  (w_empty[c])
        );
    end

    assign w_drop = bus.din_en & ~w_accept;

    // Scan downwards so the column closest to r_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_col = '0;
        for (int k = nCols - 1; k >= 0; k--) begin
            if (!w_empty[(int'(r_ptr) + k) % nCols]) begin
                w_gnt_vld = 1'b1;
                w_gnt_col = CW'((int'(r_ptr) + k) % nCols);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = (r_state == ST_EMPTY) || bus.out_ready;
        w_take      = w_load && w_gnt_vld;
        w_pop       = '0;
        if (w_take) begin
            w_pop = nCols'(1) << w_gnt_col;
        end
        if (w_load) begin
            w_state_nxt = w_gnt_vld ? ST_HOLD : ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
            r_col  <= '0;
            r_ptr  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_take) begin
                r_data <= w_fifo_dat[w_gnt_col];
                r_col  <= w_gnt_col;
                r_ptr  <= (w_gnt_col == CW'(nCols - 1)) ? '0 : w_gnt_col + CW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (|w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_col   = r_col;
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: quantize, rounding, saturation, round-robin, overflow, backpressure, reset.
module tb_systolic_drain;
    import arthas_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    systolic_drain_if bus ();

    systolic_drain #(
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SYSTOLIC_DRAIN_ROUND_EN
    localparam logic [31:0] EXP_Q    = 32'hEDCC_1234;
    localparam logic [31:0] EXP_RND  = 32'h0000_0002;
`else
    localparam logic [31:0] EXP_Q    = 32'hEDCB_1234;
    localparam logic [31:0] EXP_RND  = 32'h0000_0001;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int c, input int b, input logic [32:0] v);
        bus.din[(b*NCOLS+c)*OWIDTH +: OWIDTH] = v;
    endtask

    task automatic push1(input int c, input logic [32:0] b0, input logic [32:0] b1);
        set_word(c, 0, b0);
        set_word(c, 1, b1);
        bus.din_en = 4'b0001 << c;
        tick();
        bus.din_en = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic single(input string tag, input int c, input logic [32:0] b0,
                          input logic [32:0] b1, input logic [31:0] exp);
        bus.out_ready = 1'b1;
        push1(c, b0, b1);
        wait_valid({tag, "_vld"});
        chk(tag, 64'(bus.out_data), 64'(exp));
        chk({tag, "_col"}, 64'(bus.out_col), 64'(c));
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.din_en = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        bus.shift     = 5'd0;
        bus.din_en    = '0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        tick();
        tick();
        chk("rst_vld",  64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data),  64'd0);
        chk("rst_col",  64'(bus.out_col),   64'd0);
        chk("rst_ovf",  64'(bus.overflow),  64'd0);
        rst = 1'b1;
        tick();
        chk("idle_vld", 64'(bus.out_valid), 64'd0);

        // Quantize with exact 2-cycle latency
        bus.shift     = 5'd4;
        bus.out_ready = 1'b1;
        set_word(0, 0, 33'h0_0001_2345);
        set_word(0, 1, -33'h0_0001_2345);
        bus.din_en = 4'b0001;
        tick();
        bus.din_en = '0;
        chk("lat_t1", 64'(bus.out_valid), 64'd0);
        tick();
        chk("lat_t2", 64'(bus.out_valid), 64'd1);
        chk("quant",  64'(bus.out_data),  64'(EXP_Q));
        chk("quant_col", 64'(bus.out_col), 64'd0);
        tick();
        chk("quant_drained", 64'(bus.out_valid), 64'd0);

        single("round", 0, 33'h18, 33'h0, EXP_RND);

        bus.shift = 5'd0;
        single("sat_pm",  2, 33'h0_0010_0000, -33'h0_0010_0000, 32'h8000_7FFF);
        single("sat_max", 3, 33'h0_FFFF_FFFF, 33'h1_0000_0000, 32'h8000_7FFF);

        // Round-robin from pointer 0 after reset
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < NCOLS; c++) begin
            set_word(c, 0, 33'(c + 1));
            set_word(c, 1, 33'h0);
        end
        bus.din_en = 4'b1111;
        tick();
        bus.din_en = '0;
        chk("rr_lat", 64'(bus.out_valid), 64'd0);
        tick();
        for (int i = 0; i < NCOLS; i++) begin
            chk("rr_vld",  64'(bus.out_valid), 64'd1);
            chk("rr_col",  64'(bus.out_col),   64'(i));
            chk("rr_data", 64'(bus.out_data),  64'(i + 1));
            tick();
        end
        chk("rr_done", 64'(bus.out_valid), 64'd0);

        // Pointer at 3 must serve column 3 before wrapping to 0
        single("ptr_set", 2, 33'h22, 33'h0, 32'h0000_0022);
        set_word(0, 0, 33'h30);
        set_word(3, 0, 33'h33);
        bus.din_en = 4'b1001;
        tick();
        bus.din_en = '0;
        wait_valid("wrap_vld");
        chk("wrap_col0", 64'(bus.out_col), 64'd3);
        tick();
        chk("wrap_col1", 64'(bus.out_col), 64'd0);
        chk("wrap_data1", 64'(bus.out_data), 64'h30);
        tick();

        // Overflow: DEPTH+1 accepted, sixth dropped
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_word(0, 0, 33'(i + 1));
            set_word(0, 1, 33'h0);
            bus.din_en = 4'b0001;
            tick();
            bus.din_en = '0;
            if (i == 4) chk("ovf_before", 64'(bus.overflow), 64'd0);
        end
        chk("ovf_set",   64'(bus.overflow),  64'd1);
        chk("ovf_hold",  64'(bus.out_data),  64'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", 64'(bus.overflow), 64'd0);

        // Full FIFO with simultaneous push and pop keeps the push
        set_word(0, 0, 33'h7);
        bus.din_en    = 4'b0001;
        bus.out_ready = 1'b1;
        tick();
        bus.din_en = '0;
        chk("full_pushpop_ovf", 64'(bus.overflow), 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk("drain_vld",  64'(bus.out_valid), 64'd1);
            chk("drain_data", 64'(bus.out_data),  64'((i < 4) ? i + 2 : 7));
            tick();
        end
        chk("drain_done", 64'(bus.out_valid), 64'd0);

        // Backpressure stability, then reset discards everything
        bus.out_ready = 1'b0;
        push1(1, 33'h55, 33'h66);
        push1(1, 33'h77, 33'h88);
        wait_valid("bp_vld");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stable_vld",  64'(bus.out_valid), 64'd1);
            chk("bp_stable_data", 64'(bus.out_data),  64'h0066_0055);
            chk("bp_stable_col",  64'(bus.out_col),   64'd1);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_vld", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_vld", 64'(bus.out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output collector for the systolic array. It captures the per-column `dout_en`/`dout` results of every bank and requantizes each 33-bit accumulator to a 16-bit signed word. Results are buffered in per-column FIFOs and drained over a single valid/ready stream, one column (all banks packed) per beat, using round-robin arbitration. The block sits between the array outputs and the result write-back path.

## Interface
Parameters:
- `nBanks`, 2, banks per column beat
- `nCols`, 4, array columns (one FIFO each)
- `oWidth`, 33, accumulator width from array
- `qWidth`, 16, requantized word width
- `DEPTH`, 4, entries per column FIFO (power of 2)

Ports (one clock; `rst` is synchronous, active-low):
- `clk` in 1, clock
- `rst` in 1, synchronous active-low reset
- `shift` in 5, arithmetic right-shift amount; must be static while any `din_en` can pulse
- `din_en` in nCols, per-column result strobe from array
- `din` in nBanks*nCols*oWidth, bank b / column c at offset (b*nCols+c)*oWidth
- `out_valid` out 1, output beat valid
- `out_ready` in 1, downstream accept
- `out_data` out nBanks*qWidth, bank b at offset b*qWidth
- `out_col` out clog2(nCols), column index of beat
- `overflow` out 1, sticky drop flag
- `ovf_clr` in 1, clears `overflow`

## Operation
- Quantize on capture, per bank word: signed value >>> `shift` (with optional rounding), then saturate to [-2^(qWidth-1), 2^(qWidth-1)-1].
- `din_en[c]`=1 pushes one entry (all nBanks quantized words) into FIFO c.
- A push is accepted if count<DEPTH, or if FIFO c pops in the same cycle. Otherwise the entry is dropped and `overflow` is set.
- Output register state is EMPTY or HOLD:
  - EMPTY, or HOLD with `out_ready`=1: the arbiter pops one non-empty FIFO into the register.
  - HOLD with `out_ready`=0: no pop; `out_data`/`out_col` stay stable.
- Arbiter is round-robin. It scans from `ptr`; after a grant of column c, `ptr`=c+1 mod nCols.
- `overflow` is sticky. A set (drop) in the same cycle as `ovf_clr` wins.
- Reset values: `out_valid`=0, `out_data`=0, `out_col`=0, `overflow`=0, `ptr`=0. All FIFOs are emptied.
- Reset mid-stream discards buffered and held data without producing an output beat.

## Timing
- Push at edge t makes the FIFO non-empty at t+1. The earliest pop is at edge t+1, so `out_valid` rises at t+2 (2-cycle latency).
- Throughput is one beat per cycle while `out_ready`=1 and any FIFO is non-empty.
- Total capacity per column is DEPTH+1 (FIFO plus output register, if the register holds that column).
- All nCols columns may push in the same cycle.
- Full FIFO with simultaneous push and pop: the push is accepted and count is unchanged.
- Pointer wrap: from column nCols-1 the pointer returns to column 0.

## Configuration
- `SYSTOLIC_DRAIN_ROUND_EN` defined: before shifting, add 2^(shift-1) when shift>0. This gives round-half-up. The addition is done at oWidth+1 bits, so no wrap occurs.
- Not defined: plain truncating arithmetic shift. Saturation is identical in both modes.

## Structure
- Shared package `arthas_pkg`: constants `NBANKS`, `NCOLS`, `QWIDTH`, `OWIDTH`; typedef for the packed column word; function `quantize(value, shift)`.
- Sub-module `drain_col_fifo`: synchronous FIFO with count, push/pop, and the full-with-pop acceptance rule. It is instantiated nCols times.
- Top level holds the quantizers, the round-robin arbiter, the output register and the overflow flag.

## Test plan
- Quantize: shift=4, bank0 din=0x12345, bank1 din=-0x12345, col0 pulse. Expected `out_data` = {0xEDCC, 0x1234} (bank1 high) with rounding; {0xEDCB, 0x1234} without rounding.
- Rounding: din=0x18, shift=4. Expected 0x0002 with `SYSTOLIC_DRAIN_ROUND_EN`, 0x0001 without.
- Saturation: shift=0, din=0x100000 gives 0x7FFF; din=-0x100000 gives 0x8000; din=2^32-1 gives 0x7FFF.
- Round-robin: `din_en`=4'b1111 for one cycle, `out_ready`=1. Expected `out_col` = 0,1,2,3 on four consecutive cycles starting two cycles after the push.
- Overflow: `out_ready`=0, DEPTH=4, `din_en[0]` high for 6 cycles. Expected: 5 entries accepted, 6th dropped, `overflow`=1. Draining yields exactly 5 beats in push order. `ovf_clr` then clears the flag.
- Backpressure/reset: with `out_valid`=1, hold `out_ready`=0 for 3 cycles; `out_data` must stay stable. Then drive `rst`=0 for one cycle: `out_valid`=0 next cycle and no beats follow.
